// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues word requests to instruction
// memory, keeps the returned words in a small prefetch FIFO and hands
// {pc, instr} to decode over a valid/ready pair. A redirect restarts fetch
// at a new address and drops every response that is still in flight.
module fetch_unit #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        halt_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]   fetch_addr;
    logic [31:0]   resp_pc;
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW:0]   in_use;
    logic [31:0]   redirect_word;
    logic          gnt_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        n = p + PW'(1);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            n = '0;
        end
        return n;
    endfunction

    // Buffered entries plus requests in flight can never exceed the FIFO,
    // so every response that comes back is guaranteed a slot.
    assign in_use        = {1'b0, count} + {1'b0, outstanding};
    assign instr_req_o   = ~rst_i & (state_q == RUN) & ~halt_i & ~redirect_i
                         & (in_use < (CW + 1)'(FIFO_DEPTH));
    assign instr_addr_o  = fetch_addr;
    assign redirect_word = {redirect_addr_i[31:2], 2'b00};

    assign gnt_fire  = instr_req_o & instr_gnt_i;
    assign resp_fire = instr_rvalid_i & (outstanding != '0);
    assign push      = resp_fire & (discard == '0) & ~redirect_i;
    assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : '0;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr] : '0;

    // State register for the run/halt controller.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt is level-sensitive; a redirect also wakes a halted fetcher.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_i) state_d = HALT;
            HALT:    if (!halt_i || redirect_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Address, response-PC, FIFO pointer and in-flight bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr  <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old
            // stream; a response landing right now is consumed here.
            fetch_addr  <= redirect_word;
            resp_pc     <= redirect_word;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(resp_fire);
            discard     <= outstanding - CW'(resp_fire);
        end else begin
            if (gnt_fire) begin
                fetch_addr <= fetch_addr + 32'd4;
            end
            outstanding <= outstanding + CW'(gnt_fire) - CW'(resp_fire);
            if (resp_fire && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr  <= ptr_next(wr_ptr);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= instr_rdata_i;
        end
    end

    // A response with nothing outstanding breaks the memory protocol.
    rvalid_without_request : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(instr_rvalid_i && (outstanding == '0))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a bench-side memory
// model and a scoreboard; the monitor pops expected {pc, instr} pairs
// whenever decode accepts an entry.
module tb_fetch_unit;

    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] BOOT_ADDR  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic [63:0] exp_q [$];
    pend_t       pend_q [$];

    int          cyc         = 0;
    int          resp_lat    = 0;
    int          gnt_wait    = 0;
    int          req_age     = 0;
    int          grant_count = 0;
    logic [31:0] model_next  = BOOT_ADDR;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] held_addr   = 32'h0;
    logic        held        = 1'b0;

    fetch_unit #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .BOOT_ADDR (BOOT_ADDR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_o    (req),
        .instr_addr_o   (addr),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .instr_valid_o  (valid),
        .instr_o        (instr),
        .pc_o           (pc),
        .instr_ready_i  (ready),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .halt_i         (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic h, input logic rd,
                                 input logic [31:0] ra, input logic [31:0] tgt);
        @(negedge clk);
        rst             = r;
        ready           = rdy;
        halt            = h;
        redirect        = rd;
        redirect_addr   = ra;
        redirect_target = tgt;
    endtask

    task automatic wait_valid(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #3;
            found = valid;
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #3;
            done = (exp_q.size() == 0) && (pend_q.size() == 0) && !valid;
        end
        checkOutput("drain_idle", 32'(done), 32'd1);
    endtask

    // Memory model: grants after gnt_wait cycles of a held request, answers
    // in order resp_lat cycles after the usual next-cycle response.
    initial begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
                rvalid = 1'b1;
                rdata  = mem_data(pend_q[0].addr);
            end else begin
                rvalid = 1'b0;
                rdata  = 32'h0;
            end
            #2;
            gnt = req && (req_age >= gnt_wait);
            #2;
            if (rst) begin
                pend_q.delete();
                model_next = BOOT_ADDR;
                req_age    = 0;
                held       = 1'b0;
            end else begin
                if (redirect) model_next = redirect_target;
                if (rvalid) void'(pend_q.pop_front());
                if (req && gnt) begin
                    checkOutput("grant_addr", addr, model_next);
                    exp_q.push_back({model_next, mem_data(model_next)});
                    pend_q.push_back('{addr: addr, due: cyc + 1 + resp_lat});
                    grant_count++;
                    model_next = model_next + 32'd4;
                    req_age    = 0;
                    held       = 1'b0;
                end else if (req) begin
                    if (held) checkOutput("addr_stable", addr, held_addr);
                    held      = 1'b1;
                    held_addr = addr;
                    req_age++;
                end else begin
                    req_age = 0;
                    held    = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted entry must match the head of the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst || redirect) begin
                exp_q.delete();
            end else if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_entry: got pc %h, expected no entry", pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pc_o", pc, e[63:32]);
                    checkOutput("instr_o", instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int g0;
        logic found;
        rst             = 1'b1;
        ready           = 1'b0;
        halt            = 1'b0;
        redirect        = 1'b0;
        redirect_addr   = 32'h0;
        redirect_target = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("reset_req",   32'(req),   32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_instr", instr,      32'h0);
        checkOutput("reset_pc",    pc,         32'h0);

        // Decode stalled: only FIFO_DEPTH requests may go out
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        #3;
        checkOutput("stall_grants", 32'(grant_count), 32'd2);
        checkOutput("stall_req",    32'(req),         32'd0);
        checkOutput("stall_valid",  32'(valid),       32'd1);
        checkOutput("stall_pc",     pc,               32'h0000_0000);
        checkOutput("stall_instr",  instr,            32'hC0DE_FFFF);

        // Release decode and stream, then halt mid-stream and resume
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (12) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        g0 = grant_count;
        repeat (8) @(negedge clk);
        #3;
        checkOutput("halt_no_grant", 32'(grant_count), 32'(g0));
        checkOutput("halt_drained",  32'(valid),       32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);

        // Grant held back three cycles per request
        gnt_wait = 3;
        repeat (20) @(negedge clk);
        gnt_wait = 0;
        drain();

        // Redirect to 0x100 with two requests in flight
        resp_lat = 4;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = (pend_q.size() == 2);
        end
        checkOutput("two_in_flight", 32'(found), 32'd1);
        redirect        = 1'b1;
        redirect_addr   = 32'h0000_0100;
        redirect_target = 32'h0000_0100;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_valid("redir_valid");
        checkOutput("redir_pc",    pc,    32'h0000_0100);
        checkOutput("redir_instr", instr, 32'hC1DE_FEFF);
        resp_lat = 0;
        repeat (10) @(negedge clk);

        // Unaligned redirect landing together with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            #1;
            found = valid && rvalid;
        end
        checkOutput("collision_found", 32'(found), 32'd1);
        redirect        = 1'b1;
        redirect_addr   = 32'h0000_0103;
        redirect_target = 32'h0000_0100;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_valid("unaligned_valid");
        checkOutput("unaligned_pc",    pc,    32'h0000_0100);
        checkOutput("unaligned_instr", instr, 32'hC1DE_FEFF);
        repeat (6) @(negedge clk);

        // Back-to-back redirects from HALT: the second one wins
        drain();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0200);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0300);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_valid("double_valid");
        checkOutput("double_pc",    pc,    32'h0000_0300);
        checkOutput("double_instr", instr, 32'hC3DE_FCFF);
        repeat (6) @(negedge clk);

        // Address wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_valid("wrap_valid");
        checkOutput("wrap_pc",    pc,    32'hFFFF_FFF8);
        checkOutput("wrap_instr", instr, 32'h3F26_0007);
        repeat (12) @(negedge clk);

        // Reset pulse mid-transfer restarts at the boot address
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_req",   32'(req),   32'd1);
        checkOutput("rst_addr",  addr,       BOOT_ADDR);
        wait_valid("rst_first_valid");
        checkOutput("rst_first_pc", pc, BOOT_ADDR);
        repeat (10) @(negedge clk);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
